timestamp_timer: RTL and testbench
==================================

Name: timestamp_timer

Overview:
- Parametrised fixed-point timestamp counter. Successor to the real-valued clock model; fully synthesizable.
- Adds a programmable fractional increment, synchronous clear/load, wrap indication, NUM_CMP compare channels with sticky match flags and an interrupt.
- Sits on the IO-device bus side; timestamp is readable by the core and drives timed IO events.

Parameters:
- WIDTH, 32, total timestamp width in bits (unsigned fixed point).
- FRAC_BITS, 16, fractional bits; the format is Q(WIDTH-FRAC_BITS).FRAC_BITS; 0 <= FRAC_BITS < WIDTH.
- NUM_CMP, 2, number of compare channels; 1..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  count enable.
- incr  in  WIDTH  per-cycle increment, same fixed-point format as timestamp.
- clear  in  1  synchronous clear pulse.
- load_en  in  1  synchronous load strobe.
- load_value  in  WIDTH  value written on load_en.
- cmp_value  in  NUM_CMP*WIDTH  compare thresholds; channel i is at bits [i*WIDTH +: WIDTH].
- match_clr  in  NUM_CMP  per-channel sticky-flag clear.
- irq_mask  in  NUM_CMP  per-channel interrupt enable.
- timestamp  out  WIDTH  current timestamp.
- wrap  out  1  one-cycle pulse on wrap-around.
- match  out  NUM_CMP  sticky compare-match flags.
- irq  out  1  OR of (match & irq_mask), registered.
- capture_in  in  1  external capture event (used only with the optional feature).
- capture_value  out  WIDTH  captured timestamp.
- capture_valid  out  1  captured value pending.
- capture_ack  in  1  releases capture_valid.

Behaviour:
- Reset, asynchronous: timestamp, wrap, match, irq, capture_value and capture_valid all go to 0 immediately and stay 0 while reset is high.
- Update priority at each edge: clear > load_en > enable.
  - clear: timestamp <= 0.
  - load_en: timestamp <= load_value.
  - enable: timestamp <= (timestamp + incr) mod 2^WIDTH.
  - none of these: hold.
- The next value is the (WIDTH+1)-bit sum; the carry bit is the wrap condition.
- wrap = 1 for exactly one cycle, the same edge the wrapped value appears, and only on an enable-driven increment. clear and load never assert wrap.
- incr = 0 with enable high: timestamp holds and no event fires.
- Compare crossing for channel i, with cur = pre-edge value, nxt = post-edge value, c = cmp_value[i], evaluated only on enable-driven increments:
  - no wrap: crossing when cur < c <= nxt;
  - wrap: crossing when cur < c OR c <= nxt.
  - This catches thresholds skipped by fractional or large increments.
- clear and load never set match flags.
- match[i] is set on the same edge the crossing value appears. It stays set until match_clr[i].
- Simultaneous set and match_clr on a channel: set wins.
- irq is registered from the post-edge flags, so it is 1 cycle after match.
- cmp_value changes take effect on the next evaluation; there is no retroactive match.

Optional Feature:
- Macro: TIMESTAMP_CAPTURE_EN.
- With the macro:
  - capture_in passes through a 2-flop synchroniser, then rising-edge detection.
  - On a detected edge, capture_value <= timestamp (value at that edge, before update) and capture_valid <= 1.
  - capture_ack clears capture_valid.
  - Edge and ack in the same cycle: the new capture wins and valid stays 1.
  - An edge while valid=1 overwrites capture_value (latest wins).
  - Latency from capture_in to capture_valid is 3 edges.
- Without the macro: ports remain; capture_value = 0, capture_valid = 0, capture_in and capture_ack are ignored.

Decomposition:
- Package timer_pkg holds:
  - default WIDTH/FRAC_BITS/NUM_CMP constants;
  - MAX_CMP = 8;
  - a to_fixed constant function (integer and fraction to Q-format) for benches.
- Sub-module timer_cmp_channel, instantiated NUM_CMP times:
  - inputs cur, nxt, carry, inc_valid, cmp, clr;
  - output: sticky match.

Test Plan (WIDTH=32, FRAC_BITS=16):
- incr=0x0000_8000 (0.5), enable for 4 cycles from reset -> timestamp=0x0002_0000; wrap never asserted.
- load 0xFFFF_F000, incr=0x0000_1000, enable 1 cycle -> timestamp=0x0000_0000, wrap=1 for one cycle, then 0.
- cmp_value[0]=0x0001_4000, incr=0x8000 from 0 -> match[0] rises on the edge timestamp becomes 0x0001_8000; with irq_mask[0]=1, irq rises one cycle later; match_clr[0] and crossing in the same cycle -> match[0] stays 1.
- clear, load_en and enable all high with load_value=0x1234 -> timestamp=0, no wrap, no match.
- Reset asserted mid-count (timestamp=0x0003_0000, match=2'b01) -> all outputs 0 asynchronously, before the next clk edge; counting resumes from 0 after release.
- With TIMESTAMP_CAPTURE_EN: pulse capture_in at timestamp=0x0001_0000 (incr=0x1000) -> capture_valid=1 three edges later, capture_value=0x0001_2000; capture_ack -> valid=0. Without the macro -> capture_valid stays 0.

Source files
------------

// File: rtl/timestamp_timer_pkg.sv
// timer_pkg: shared constants and a Q-format helper for timestamp_timer.
// Contents: default WIDTH/FRAC_BITS/NUM_CMP, MAX_CMP, to_fixed().
package timer_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_FRAC_BITS = 16;
  localparam int DEF_NUM_CMP   = 2;
  localparam int MAX_CMP       = 8;

  // Build a default-format value from an integer part and a raw
  // fractional field (units of 2^-DEF_FRAC_BITS).
  function automatic logic [DEF_WIDTH-1:0] to_fixed(
    input int unsigned int_part,
    input int unsigned frac_part
  );
    logic [63:0] v;
    v = (64'(int_part) << DEF_FRAC_BITS)
      | (64'(frac_part) & ((64'd1 << DEF_FRAC_BITS) - 64'd1));
    return v[DEF_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/timestamp_timer_if.sv
// timestamp_timer_if: control/status bundle of the timestamp timer.
// master drives enable/incr/clear/load/cmp/capture strobes; slave returns
// timestamp, wrap, match, irq and the capture result.
interface timestamp_timer_if
  import timer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_CMP = DEF_NUM_CMP
);

  logic                     enable;
  logic [WIDTH-1:0]         incr;
  logic                     clear;
  logic                     load_en;
  logic [WIDTH-1:0]         load_value;
  logic [NUM_CMP*WIDTH-1:0] cmp_value;
  logic [NUM_CMP-1:0]       match_clr;
  logic [NUM_CMP-1:0]       irq_mask;
  logic [WIDTH-1:0]         timestamp;
  logic                     wrap;
  logic [NUM_CMP-1:0]       match;
  logic                     irq;
  logic                     capture_in;
  logic [WIDTH-1:0]         capture_value;
  logic                     capture_valid;
  logic                     capture_ack;

  modport master (
    output enable, incr, clear, load_en, load_value,
    output cmp_value, match_clr, irq_mask,
    output capture_in, capture_ack,
    input  timestamp, wrap, match, irq,
    input  capture_value, capture_valid
  );

  modport slave (
    input  enable, incr, clear, load_en, load_value,
    input  cmp_value, match_clr, irq_mask,
    input  capture_in, capture_ack,
    output timestamp, wrap, match, irq,
    output capture_value, capture_valid
  );

endinterface

// File: rtl/timestamp_timer_cmp_channel.sv
// timer_cmp_channel: one compare channel with a sticky match flag.
// Ports: clk, reset, cur/nxt/carry/inc_valid, cmp, clr -> match.
module timer_cmp_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] nxt,
  input  logic             carry,
  input  logic             inc_valid,
  input  logic [WIDTH-1:0] cmp,
  input  logic             clr,
  output logic             match
);

  logic match_q, match_d;
  logic hit;

  // On wrap the crossed range is (cur, MAX] U [0, nxt].
  always_comb begin
    hit = 1'b0;
    if (inc_valid) begin
      if (carry) hit = (cur < cmp) | (cmp <= nxt);
      else       hit = (cur < cmp) & (cmp <= nxt);
    end
    match_d = hit | (match_q & ~clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) match_q <= 1'b0;
    else       match_q <= match_d;
  end

  assign match = match_q;

endmodule

// File: rtl/timestamp_timer.sv
// timestamp_timer: fixed-point timestamp counter with compare channels.
// Ports: clk, reset, bus (timestamp_timer_if.slave). Optional macro
// TIMESTAMP_CAPTURE_EN enables the synchronised capture unit.
module timestamp_timer
  import timer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int NUM_CMP   = DEF_NUM_CMP
) (
  input logic               clk,
  input logic               reset,
  timestamp_timer_if.slave  bus
);

  if (FRAC_BITS < 0 || FRAC_BITS >= WIDTH ||
      NUM_CMP < 1 || NUM_CMP > MAX_CMP) begin : g_bad_cfg
    $error("timestamp_timer: illegal parameters");
  end

  logic [WIDTH-1:0]   ts_q, ts_d;
  logic               wrap_q, wrap_d;
  logic               irq_q;
  logic [WIDTH:0]     sum;
  logic               carry;
  logic               do_clr, do_load, inc_valid;
  logic [NUM_CMP-1:0] match;

  assign sum       = {1'b0, ts_q} + {1'b0, bus.incr};
  assign carry     = sum[WIDTH];
  assign do_clr    = bus.clear;
  assign do_load   = bus.load_en & ~bus.clear;
  assign inc_valid = bus.enable & ~bus.load_en & ~bus.clear;

  always_comb begin
    ts_d   = ts_q;
    wrap_d = 1'b0;
    unique case (1'b1)
      do_clr:    ts_d = '0;
      do_load:   ts_d = bus.load_value;
      inc_valid: begin
        ts_d   = sum[WIDTH-1:0];
        wrap_d = carry;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q   <= '0;
      wrap_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ts_q   <= ts_d;
      wrap_q <= wrap_d;
      irq_q  <= |(match & bus.irq_mask);
    end
  end

  for (genvar g = 0; g < NUM_CMP; g++) begin : g_ch
    timer_cmp_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .cur       (ts_q),
      .nxt       (sum[WIDTH-1:0]),
      .carry     (carry),
      .inc_valid (inc_valid),
      .cmp       (bus.cmp_value[g*WIDTH +: WIDTH]),
      .clr       (bus.match_clr[g]),
      .match     (match[g])
    );
  end

  assign bus.timestamp = ts_q;
  assign bus.wrap      = wrap_q;
  assign bus.match     = match;
  assign bus.irq       = irq_q;

`ifdef TIMESTAMP_CAPTURE_EN
  // [0],[1] synchronise; [2] holds the previous synced level.
  logic [2:0]       sync_q;
  logic [WIDTH-1:0] cap_q;
  logic             capv_q;
  logic             cap_edge;

  assign cap_edge = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      cap_q  <= '0;
      capv_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], bus.capture_in};
      if (cap_edge) cap_q <= ts_q;
      capv_q <= cap_edge | (capv_q & ~bus.capture_ack);
    end
  end

  assign bus.capture_value = cap_q;
  assign bus.capture_valid = capv_q;
`else
  logic unused_cap;
  assign unused_cap        = bus.capture_in ^ bus.capture_ack;
  assign bus.capture_value = '0;
  assign bus.capture_valid = 1'b0;
`endif

endmodule

// File: tb/tb_timestamp_timer.sv
// tb_timestamp_timer: directed + random test of timestamp_timer against
// an arithmetic reference model.
module tb_timestamp_timer;
  import timer_pkg::*;

  localparam int W = 32;
  localparam int N = 2;
  localparam longint unsigned MOD = 64'h1_0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  timestamp_timer_if #(.WIDTH(W), .NUM_CMP(N)) bus ();

  timestamp_timer #(.WIDTH(W), .FRAC_BITS(16), .NUM_CMP(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model
  longint unsigned m_ts, m_capv;
  bit              m_wrap, m_irq, m_capvalid;
  bit [N-1:0]      m_match, hitv;
  bit              cin_h[3];
  longint unsigned cur, sum, c;
  bit              edge_seen;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ts = 0; m_capv = 0; m_wrap = 0; m_irq = 0;
      m_capvalid = 0; m_match = '0;
      cin_h[0] = 0; cin_h[1] = 0; cin_h[2] = 0;
    end else begin
      cur = m_ts;
      // edge seen when capture_in was 1 two edges ago and 0 three ago
      edge_seen = cin_h[1] && !cin_h[2];
      cin_h[2] = cin_h[1];
      cin_h[1] = cin_h[0];
      cin_h[0] = bus.capture_in;
`ifdef TIMESTAMP_CAPTURE_EN
      if (edge_seen) begin
        m_capv = cur; m_capvalid = 1;
      end else if (bus.capture_ack) m_capvalid = 0;
`endif
      m_irq  = |(m_match & bus.irq_mask);
      m_wrap = 0;
      hitv   = '0;
      if (bus.clear) m_ts = 0;
      else if (bus.load_en) m_ts = bus.load_value;
      else if (bus.enable) begin
        sum    = cur + longint'(bus.incr);
        m_wrap = (sum >= MOD);
        m_ts   = sum % MOD;
        for (int i = 0; i < N; i++) begin
          c = bus.cmp_value[i*W +: W];
          if ((c > cur && c <= sum) ||
              (c + MOD > cur && c + MOD <= sum))
            hitv[i] = 1;
        end
      end
      m_match = (m_match & ~bus.match_clr) | hitv;
    end
  end

  // Continuous compare on every falling edge out of reset
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("ts",    bus.timestamp,     m_ts);
      chk("wrap",  bus.wrap,          m_wrap);
      chk("match", bus.match,         m_match);
      chk("irq",   bus.irq,           m_irq);
      chk("capv",  bus.capture_value, m_capv);
      chk("capok", bus.capture_valid, m_capvalid);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cmp(input logic [W-1:0] c0, input logic [W-1:0] c1);
    bus.cmp_value = {c1, c0};
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 0; bus.incr = '0; bus.clear = 0; bus.load_en = 0;
    bus.load_value = '0; bus.cmp_value = '0; bus.match_clr = '0;
    bus.irq_mask = '0; bus.capture_in = 0; bus.capture_ack = 0;
    step(2);
    chk("rst_ts",    bus.timestamp, 0);
    chk("rst_wrap",  bus.wrap, 0);
    chk("rst_match", bus.match, 0);
    chk("rst_irq",   bus.irq, 0);
    chk("rst_capok", bus.capture_valid, 0);
    reset = 1'b0;

    // half increments
    bus.incr = 32'h0000_8000; bus.enable = 1;
    step(4);
    chk("half4_ts", bus.timestamp, 32'h0002_0000);
    chk("half4_wrap", bus.wrap, 0);
    bus.enable = 0;

    // wrap-around
    bus.load_en = 1; bus.load_value = 32'hFFFF_F000;
    step();
    bus.load_en = 0; bus.enable = 1; bus.incr = 32'h0000_1000;
    step();
    chk("wrap_ts", bus.timestamp, 0);
    chk("wrap_hi", bus.wrap, 1);
    bus.enable = 0;
    step();
    chk("wrap_lo", bus.wrap, 0);

    // compare, irq, clear-vs-set
    bus.clear = 1; bus.match_clr = '1; bus.irq_mask = 2'b01;
    set_cmp(32'h0001_4000, 32'hFFFF_FFFF);
    step();
    bus.clear = 0; bus.match_clr = '0;
    chk("cmp_clr", bus.match, 0);
    bus.incr = 32'h0000_8000; bus.enable = 1;
    step(2);
    chk("cmp_pre", bus.match, 0);
    step();
    chk("cmp_ts",  bus.timestamp, 32'h0001_8000);
    chk("cmp_hit", bus.match, 2'b01);
    chk("irq_lag", bus.irq, 0);
    bus.enable = 0;
    step();
    chk("irq_hi", bus.irq, 1);
    set_cmp(32'h0001_C000, 32'hFFFF_FFFF);
    bus.match_clr = 2'b01; bus.enable = 1;
    step();
    chk("setwin", bus.match[0], 1);
    bus.enable = 0; bus.match_clr = '1;
    step();
    bus.match_clr = '0;
    chk("mclr", bus.match, 0);

    // priority: clear beats load and enable
    bus.clear = 1; bus.load_en = 1; bus.load_value = 32'h1234;
    bus.enable = 1; set_cmp(32'h1234, 32'h0000_8000);
    step();
    chk("prio_ts", bus.timestamp, 0);
    chk("prio_wrap", bus.wrap, 0);
    chk("prio_match", bus.match, 0);
    bus.clear = 0; bus.load_en = 0;

    // async reset mid-count
    bus.clear = 1; set_cmp(32'h0002_8000, 32'h8000_0000);
    step();
    bus.clear = 0; bus.enable = 1; bus.incr = 32'h0000_8000;
    step(6);
    chk("mid_ts", bus.timestamp, 32'h0003_0000);
    chk("mid_match", bus.match, 2'b01);
    #2 reset = 1'b1;
    #1;
    chk("arst_ts",    bus.timestamp, 0);
    chk("arst_match", bus.match, 0);
    chk("arst_irq",   bus.irq, 0);
    chk("arst_wrap",  bus.wrap, 0);
    step();
    reset = 1'b0;
    step();
    chk("resume_ts", bus.timestamp, 32'h0000_8000);

    // capture
    bus.enable = 0; bus.load_en = 1; bus.load_value = 32'h0001_0000;
    bus.incr = 32'h0000_1000;
    step();
    bus.load_en = 0; bus.enable = 1; bus.capture_in = 1;
    step();
    bus.capture_in = 0;
    step(2);
`ifdef TIMESTAMP_CAPTURE_EN
    chk("cap_valid", bus.capture_valid, 1);
    chk("cap_value", bus.capture_value, 32'h0001_2000);
    bus.capture_ack = 1;
    step();
    bus.capture_ack = 0;
    chk("cap_ack", bus.capture_valid, 0);
`else
    chk("cap_off_v", bus.capture_valid, 0);
    chk("cap_off_d", bus.capture_value, 0);
    step();
`endif

    // random traffic
    for (int k = 0; k < 600; k++) begin
      bus.clear   = ($urandom % 40) == 0;
      bus.load_en = ($urandom % 20) == 0;
      bus.load_value = ($urandom % 2) ? {16'hFFFF, 16'($urandom)}
                                      : $urandom;
      bus.enable = ($urandom % 4) != 0;
      case ($urandom % 4)
        0: bus.incr = '0;
        1: bus.incr = $urandom_range(1, 32'h0000_4000);
        2: bus.incr = $urandom_range(1, 32'h0004_0000);
        default: bus.incr = $urandom;
      endcase
      for (int i = 0; i < N; i++)
        bus.cmp_value[i*W +: W] =
          W'(m_ts + $urandom_range(0, 32'h0002_0000));
      bus.match_clr   = (($urandom % 6) == 0) ? N'($urandom) : '0;
      bus.irq_mask    = N'($urandom);
      bus.capture_in  = ($urandom % 3) == 0;
      bus.capture_ack = ($urandom % 5) == 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
